window_serializer: RTL and testbench
====================================

// Module: window_serializer
// PURPOSE
//   Parallel-to-serial unloader for the filter's tap window: the reverse of the pixel
//   tap shift register. Captures a DEPTH-word window in one cycle, then streams it out
//   one word per accepted transfer on a valid/ready interface. Sits between the tap
//   window and any word-serial consumer (UART/VGA pixel path, checksum, memory writer).
// PARAMETERS
//   WIDTH        24  bits per word (one RGB888 pixel)
//   DEPTH        7   words per window; must be >= 2
//   OLDEST_FIRST 1   1: emit index DEPTH-1 down to 0; 0: emit index 0 up to DEPTH-1
// PORTS
//   clk_i      in   1            single clock; all logic on its rising edge
//   reset_n_i  in   1            synchronous reset, active low
//   load_i     in   1            request to capture data_i (valid for load side)
//   ready_o    in/out: out 1     high when a load will be accepted (state IDLE)
//   data_i     in   WIDTH x DEPTH window; index 0 = newest word, DEPTH-1 = oldest
//   flush_i    in   1            abort current window, return to IDLE
//   valid_o    out  1            data_o holds a word for the consumer
//   ready_i    in   1            consumer accepts data_o this cycle
//   data_o     out  WIDTH        current word
//   last_o     out  1            data_o is the final word of the window
//   busy_o     out  1            window held and not yet fully sent
// BEHAVIOUR
//   - Reset (reset_n_i==0 at an edge): state IDLE, ready_o=1, valid_o=0, last_o=0,
//     busy_o=0, data_o=0, word index=0, buffer cleared to 0. Reset overrides all inputs,
//     including mid-window; the partial window is discarded with no further output.
//   - States: IDLE, SEND.
//     IDLE: ready_o=1. load_i=1 at an edge -> copy all DEPTH words into the internal
//       buffer, index=0, go to SEND. The first word appears on data_o with valid_o=1
//       in the next cycle (1-cycle load-to-valid latency).
//     SEND: ready_o=0, valid_o=1, busy_o=1. load_i is ignored. Transfer occurs when
//       valid_o && ready_i at an edge -> index+1. data_o, valid_o, last_o hold
//       stable while ready_i=0 (no word dropped or changed while stalled).
//       Transfer with last_o=1 -> IDLE. valid_o=0 and ready_o=1 in the following
//       cycle (one bubble between windows; a new load cannot complete on the last transfer edge).
//   - Word order: k-th transfer (k=0..DEPTH-1) carries buffer[DEPTH-1-k] when
//     OLDEST_FIRST=1, buffer[k] otherwise. last_o=1 exactly on k=DEPTH-1.
//   - Index counter is $clog2(DEPTH) bits, never exceeds DEPTH-1, never wraps.
//   - data_i is sampled only on the load edge; later changes do not affect output.
//   - flush_i=1 at an edge (reset inactive): go to IDLE, valid_o=0, last_o=0,
//     index=0, regardless of ready_i. flush_i has priority over load_i and over a
//     same-cycle transfer; a transfer coinciding with flush is counted as not taken.
//   - data_o is a registered output; no combinational path from ready_i or load_i to
//     any output.
//   - Exactly DEPTH transfers per accepted load, absent flush or reset.
// TESTING
//   1 Reset: hold reset_n_i=0 3 cycles with load_i=1 -> ready_o=1, valid_o=0, data_o=0.
//   2 Load window 0x000000..0x000006 (idx0..6), ready_i=1 always -> valid_o from next
//     cycle, data_o = 06,05,04,03,02,01,00 on 7 consecutive edges, last_o only on 00,
//     then 1 bubble cycle, ready_o=1.
//   3 OLDEST_FIRST=0, same window -> 00..06 in order, last_o on 06.
//   4 Backpressure: ready_i toggles 1,0,0,1... -> data_o frozen while ready_i=0, no
//     duplicates or drops, all 7 words seen in order, load_i pulses during SEND ignored.
//   5 flush_i at third word (ready_i=1 same cycle) -> next cycle IDLE, valid_o=0, only
//     2 transfers counted; new load of 0xFFFFFF.. restarts at first word.
//   6 reset_n_i=0 mid-window (after 4 words) -> outputs go to reset values next cycle,
//     no remaining words emitted; data_i changed after load never appears on data_o.

Source files
------------

// File: rtl/window_serializer.sv
// Parallel-to-serial unloader: captures a DEPTH-word window in one cycle and streams
// it out one word per valid/ready transfer, oldest-first or newest-first.
module window_serializer #(
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned DEPTH        = 7,
    parameter bit          OLDEST_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     load_i,
    output logic                     ready_o,
    input  logic [WIDTH*DEPTH-1:0]   data_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     last_o,
    output logic                     busy_o
);

    localparam int unsigned    IW       = $clog2(DEPTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [DEPTH-1:0][WIDTH-1:0]     buf_q, buf_d;
    logic [WIDTH-1:0]                data_q, data_d;
    logic                            last_q, last_d;
    logic [DEPTH-1:0][WIDTH-1:0]     win_w;
    logic [IW-1:0]                   idx_inc_w;

    assign win_w     = data_i;
    assign idx_inc_w = idx_q + IW'(1);

    // Maps transfer number k to the buffer slot it carries.
    function automatic logic [IW-1:0] word_sel(input logic [IW-1:0] k);
        return OLDEST_FIRST ? (LAST_IDX - k) : k;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    buf_d   = win_w;
                    idx_d   = '0;
                    data_d  = win_w[word_sel('0)];
                    last_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_inc_w;
                        data_d = buf_q[word_sel(idx_inc_w)];
                        last_d = (idx_inc_w == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over both a pending load and a same-cycle transfer.
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
            buf_d   = buf_q;
            data_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == SEND);
    assign busy_o  = (state_q == SEND);
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: two instances (oldest-first and newest-first) checked
// every cycle against a queue-based model of the expected word stream.
module tb_window_serializer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned DEPTH = 7;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         load = 1'b0;
    logic                         flush = 1'b0;
    logic                         rdy_in = 1'b0;
    logic [DEPTH-1:0][WIDTH-1:0]  win = '0;

    logic                         o_ready, o_valid, o_last, o_busy;
    logic [WIDTH-1:0]             o_data;
    logic                         n_ready, n_valid, n_last, n_busy;
    logic [WIDTH-1:0]             n_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending words per ordering, plus sending flag.
    logic [WIDTH-1:0] q_old[$];
    logic [WIDTH-1:0] q_new[$];
    bit               m_send = 1'b0;
    bit               m_zero = 1'b1;

    always #5 clk = ~clk;

    window_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OLDEST_FIRST(1'b1)) u_old (
        .clk_i(clk), .reset_n_i(reset_n), .load_i(load), .ready_o(o_ready),
        .data_i(win), .flush_i(flush), .valid_o(o_valid), .ready_i(rdy_in),
        .data_o(o_data), .last_o(o_last), .busy_o(o_busy)
    );

    window_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OLDEST_FIRST(1'b0)) u_new (
        .clk_i(clk), .reset_n_i(reset_n), .load_i(load), .ready_o(n_ready),
        .data_i(win), .flush_i(flush), .valid_o(n_valid), .ready_i(rdy_in),
        .data_o(n_data), .last_o(n_last), .busy_o(n_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_send = 1'b0;
            q_old.delete();
            q_new.delete();
            m_zero = 1'b1;
        end else if (flush) begin
            m_send = 1'b0;
            q_old.delete();
            q_new.delete();
        end else if (m_send) begin
            if (rdy_in) begin
                void'(q_old.pop_front());
                void'(q_new.pop_front());
                if (q_old.size() == 0) m_send = 1'b0;
            end
        end else if (load) begin
            for (int k = 0; k < DEPTH; k++) begin
                q_old.push_back(win[DEPTH-1-k]);
                q_new.push_back(win[k]);
            end
            m_send = 1'b1;
            m_zero = 1'b0;
        end
    endtask

    task automatic check_all();
        logic exp_last;
        exp_last = m_send && (q_old.size() == 1);
        check("old_ready", 32'(o_ready), 32'(!m_send));
        check("old_valid", 32'(o_valid), 32'(m_send));
        check("old_busy",  32'(o_busy),  32'(m_send));
        check("old_last",  32'(o_last),  32'(exp_last));
        check("new_ready", 32'(n_ready), 32'(!m_send));
        check("new_valid", 32'(n_valid), 32'(m_send));
        check("new_last",  32'(n_last),  32'(exp_last));
        if (m_send) begin
            check("old_data", 32'(o_data), 32'(q_old[0]));
            check("new_data", 32'(n_data), 32'(q_new[0]));
        end else if (m_zero) begin
            check("old_data_rst", 32'(o_data), 32'h0);
            check("new_data_rst", 32'(n_data), 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_window();
        for (int i = 0; i < DEPTH; i++) win[i] = WIDTH'($urandom);
    endtask

    initial begin
        // Reset held with load asserted
        reset_n = 1'b0; load = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1; load = 1'b0;
        tick();

        // Ascending window, consumer always ready
        for (int i = 0; i < DEPTH; i++) win[i] = WIDTH'(i);
        load = 1'b1; rdy_in = 1'b1;
        tick();
        load = 1'b0;
        repeat (DEPTH + 2) tick();

        // Backpressure 1,0,0 with stray load pulses and data_i changes
        rand_window();
        load = 1'b1;
        tick();
        for (int c = 0; c < 3 * DEPTH + 3; c++) begin
            rdy_in = (c % 3 == 0);
            load   = 1'(($urandom % 3) == 0) && m_send;
            rand_window();
            tick();
        end
        load = 1'b0; rdy_in = 1'b1;
        repeat (DEPTH + 2) tick();

        // Flush while third word is offered
        rand_window();
        load = 1'b1;
        tick();
        load = 1'b0; rdy_in = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        win = '1;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (DEPTH + 2) tick();

        // Reset mid-window after four words
        rand_window();
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        rand_window();
        tick();
        reset_n = 1'b1;
        rand_window();
        repeat (DEPTH + 2) tick();

        // Random soak
        for (int c = 0; c < 400; c++) begin
            rand_window();
            load    = 1'($urandom % 2);
            rdy_in  = 1'($urandom % 2);
            flush   = (($urandom % 20) == 0);
            reset_n = (($urandom % 50) != 0);
            tick();
        end
        reset_n = 1'b1; flush = 1'b0; load = 1'b0; rdy_in = 1'b1;
        repeat (DEPTH + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
